// File: rtl/seq_detector_param.sv
// seq_detector_param: serial detector for a runtime-loadable PAT_LEN-bit pattern,
// overlapping or non-overlapping. Define SEQ_DET_COUNT_EN to add the saturating match counter.
module seq_detector_param #(
   parameter int                 PAT_LEN = 8,
   parameter logic [PAT_LEN-1:0] RST_PAT = {PAT_LEN{1'b1}},
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seq,
   input  logic               seq_vld,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               pat_load,
   input  logic               overlap,
   output logic               dout,
   output logic               busy,
   output logic [CNT_W-1:0]   match_cnt
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

   logic [PAT_LEN-1:0] pat_q, pat_d;
   logic [PAT_LEN-1:0] hist_q, hist_d;
   logic [PAT_LEN-1:0] hist_shift_s;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [FILL_W-1:0]  fill_shift_s;
   logic               dout_q, dout_d;
   logic               busy_q, busy_d;
   logic               hit_s;

   // Next-state: pattern load beats accept; a hit in non-overlap mode flushes history.
   always_comb begin
      hist_shift_s = {hist_q[PAT_LEN-2:0], seq};
      fill_shift_s = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      hit_s        = (fill_shift_s == FILL_FULL) && (hist_shift_s == pat_q);
      pat_d        = pat_q;
      hist_d       = hist_q;
      fill_d       = fill_q;
      dout_d       = 1'b0;
      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (seq_vld) begin
         dout_d = hit_s;
         if (hit_s && !overlap) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = hist_shift_s;
            fill_d = fill_shift_s;
         end
      end else begin
         dout_d = 1'b0;
      end
      busy_d = (fill_d != '0);
   end

   // Detector state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q  <= RST_PAT;
         hist_q <= '0;
         fill_q <= '0;
         dout_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         dout_q <= dout_d;
         busy_q <= busy_d;
      end
   end

   assign dout = dout_q;
   assign busy = busy_q;

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count advances together with the dout pulse and sticks at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (pat_load) begin
         cnt_d = '0;
      end else if (dout_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Match counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_cnt = cnt_q;
`else
   assign match_cnt = '0;
`endif

endmodule
